// File: rtl/neuron_mac.sv
// Per-neuron multiply-accumulate stage: streams activations against the weight
// memory, accumulates one vector, adds bias and emits a saturated Qm.f result.
module neuron_mac #(
  parameter int numWeight    = 3,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracBits     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [dataWidth-1:0]    in_data,
  input  logic                    in_valid,
  input  logic [dataWidth-1:0]    bias,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_data,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_valid,
  output logic                    out_ovf
);

  localparam int pw = 2 * dataWidth;

  localparam logic [pw-1:0]        pmax = {1'b0, {(pw-1){1'b1}}};
  localparam logic [pw-1:0]        pmin = {1'b1, {(pw-1){1'b0}}};
  localparam logic [dataWidth-1:0] dmax = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0] dmin = {1'b1, {(dataWidth-1){1'b0}}};

  logic [addressWidth-1:0] count;
  logic                    last_in;

  logic [dataWidth-1:0] in_d;
  logic                 v1, l1;
  logic [pw-1:0]        prod_r;
  logic                 v2, l2;
  logic [pw-1:0]        acc;
  logic                 acc_ovf;
  logic [pw-1:0]        sum_r;
  logic                 sum_v, sum_ovf;

  logic [pw-1:0] in_ext, w_ext, mult;
  logic [pw:0]   acc_sum;
  logic          acc_clip;
  logic [pw-1:0] acc_sat;
  logic [pw:0]   bias_sh, res_sum;
  logic          res_clip;
  logic [pw-1:0] res, shifted;
  logic          out_clip;
  logic [dataWidth-1:0] out_sat;

  assign last_in = (count == addressWidth'(numWeight - 1));
  assign w_ren   = in_valid;
  assign w_radd  = count;

  // Both factors are sign-extended to the product width, so the low half of
  // the multiply is the exact signed product.
  assign in_ext = {{dataWidth{in_d[dataWidth-1]}}, in_d};
  assign w_ext  = {{dataWidth{w_data[dataWidth-1]}}, w_data};
  assign mult   = in_ext * w_ext;

  // One guard bit on every add: overflow shows up as the top two bits differing.
  assign acc_sum  = {acc[pw-1], acc} + {prod_r[pw-1], prod_r};
  assign acc_clip = acc_sum[pw] != acc_sum[pw-1];
  assign acc_sat  = acc_clip ? (acc_sum[pw] ? pmin : pmax) : acc_sum[pw-1:0];

  assign bias_sh  = {{(pw+1-dataWidth){bias[dataWidth-1]}}, bias} << fracBits;
  assign res_sum  = {sum_r[pw-1], sum_r} + bias_sh;
  assign res_clip = res_sum[pw] != res_sum[pw-1];
  assign res      = res_clip ? (res_sum[pw] ? pmin : pmax) : res_sum[pw-1:0];

  // Arithmetic shift truncates toward -inf; the result fits only if every bit
  // above the output sign bit is a copy of it.
  assign shifted  = $signed(res) >>> fracBits;
  assign out_clip = !((&shifted[pw-1:dataWidth-1]) || !(|shifted[pw-1:dataWidth-1]));
  assign out_sat  = out_clip ? (shifted[pw-1] ? dmin : dmax) : shifted[dataWidth-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (in_valid) begin
      count <= last_in ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d   <= '0;
      v1     <= 1'b0;
      l1     <= 1'b0;
      prod_r <= '0;
      v2     <= 1'b0;
      l2     <= 1'b0;
    end else begin
      v1 <= in_valid;
      l1 <= in_valid && last_in;
      if (in_valid) begin
        in_d <= in_data;
      end
      v2 <= v1;
      l2 <= l1;
      if (v1) begin
        prod_r <= mult;
      end
    end
  end

  // The last element hands the finished sum and its sticky overflow onward and
  // restarts the accumulator, so consecutive vectors need no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      sum_r   <= '0;
      sum_v   <= 1'b0;
      sum_ovf <= 1'b0;
    end else begin
      sum_v <= v2 && l2;
      if (v2) begin
        if (l2) begin
          sum_r   <= acc_sat;
          sum_ovf <= acc_ovf | acc_clip;
          acc     <= '0;
          acc_ovf <= 1'b0;
        end else begin
          acc     <= acc_sat;
          acc_ovf <= acc_ovf | acc_clip;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= sum_v;
      if (sum_v) begin
        out_data <= out_sat;
        out_ovf  <= sum_ovf | res_clip | out_clip;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac (Q8.8, three weights) with a behavioural
// weight memory; expected results are hand-computed per directed vector.
module tb_neuron_mac;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] bias;
  logic        w_ren;
  logic [9:0]  w_radd;
  logic [15:0] w_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ovf;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        expQ[$];
  exp_t        mon_e;
  logic [15:0] biasQ[$];
  logic [15:0] mem[0:3];
  logic [2:0]  hist;
  logic        tbLast;
  int          cyc;
  int          errors;
  int          checks;

  neuron_mac #(
    .numWeight(3),
    .addressWidth(10),
    .dataWidth(16),
    .fracBits(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .bias(bias),
    .w_ren(w_ren),
    .w_radd(w_radd),
    .w_data(w_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous weight memory, one cycle of read latency.
  always @(posedge clk) begin
    if (w_ren) w_data <= mem[w_radd[1:0]];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Bias is only looked at in the output stage, three cycles after the last
  // element, so each vector's bias is applied exactly then.
  initial begin
    hist = 3'b000;
    forever begin
      @(negedge clk);
      if (hist[2] && biasQ.size() > 0) bias = biasQ.pop_front();
      hist = {hist[1:0], in_valid && tbLast};
    end
  end

  always @(negedge clk) begin
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out_valid: got data %h at cycle %0d, expected none", out_data, cyc);
      end else begin
        mon_e = expQ.pop_front();
        checkOutput("out_data", {16'h0, out_data}, {16'h0, mon_e.data});
        checkOutput("out_ovf", {31'h0, out_ovf}, {31'h0, mon_e.ovf});
        checkOutput("out_valid_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic setWeights(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
    mem[3] = 16'h0;
  endtask

  task automatic driveElem(input logic [15:0] d, input logic isLast, input int expAddr);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    tbLast   = isLast;
    #1;
    checkOutput("w_radd", {22'h0, w_radd}, expAddr);
    checkOutput("w_ren", {31'h0, w_ren}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      tbLast   = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                               input int gap0, input int gap1, input logic [15:0] b,
                               input logic [15:0] expData, input logic expOvf);
    exp_t e;
    driveElem(a0, 1'b0, 0);
    idle(gap0);
    driveElem(a1, 1'b0, 1);
    idle(gap1);
    driveElem(a2, 1'b1, 2);
    biasQ.push_back(b);
    e.data = expData;
    e.ovf  = expOvf;
    e.cyc  = cyc + 4;
    expQ.push_back(e);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    bias     = 16'h0;
    tbLast   = 1'b0;
    setWeights(16'h0100, 16'h0200, 16'hFF80);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_data", {16'h0, out_data}, 32'h0);
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_out_ovf", {31'h0, out_ovf}, 32'h0);
    checkOutput("reset_w_ren", {31'h0, w_ren}, 32'h0);
    checkOutput("reset_w_radd", {22'h0, w_radd}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 1.0*1.0 + 1.0*2.0 + 2.0*(-0.5) + 0.5 = 2.5
    applyStimulus(16'h0100, 16'h0100, 16'h0200, 0, 0, 16'h0080, 16'h0280, 1'b0);
    idle(6);
    applyStimulus(16'h0100, 16'h0100, 16'h0200, 2, 1, 16'h0080, 16'h0280, 1'b0);
    idle(6);

    applyStimulus(16'h0100, 16'h0100, 16'h0200, 0, 0, 16'h0080, 16'h0280, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1'b0);
    idle(6);

    setWeights(16'h7FFF, 16'h7FFF, 16'h7FFF);
    applyStimulus(16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 16'h7FFF, 16'h7FFF, 1'b1);
    idle(6);
    applyStimulus(16'h8000, 16'h8000, 16'h8000, 0, 0, 16'h7FFF, 16'h8000, 1'b1);
    idle(6);

    // Abort a vector after two elements; its partial sum must vanish.
    setWeights(16'h0100, 16'h0200, 16'hFF80);
    driveElem(16'h0100, 1'b0, 0);
    driveElem(16'h0100, 1'b0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tbLast   = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midreset_out_data", {16'h0, out_data}, 32'h0);
    checkOutput("midreset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midreset_w_radd", {22'h0, w_radd}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    applyStimulus(16'h0100, 16'h0100, 16'h0200, 0, 0, 16'h0080, 16'h0280, 1'b0);
    idle(6);

    // 1.0 * -0.5 with zero bias lands exactly on -0.5.
    setWeights(16'hFF80, 16'h1234, 16'h5678);
    applyStimulus(16'h0100, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'hFF80, 1'b0);
    idle(6);

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    while (expQ.size() > 0) begin
      mon_e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_out_valid: got no output, expected data %h at cycle %0d", mon_e.data, mon_e.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
